// File: rtl/agc_bank_mmu_if.sv
// Bus bundle for agc_bank_mmu: bank-register write port, translation request/response
// channels and bank-register readback. Parameters must match the MMU instance.
interface agc_bank_mmu_if #(
   parameter int EBANK_W = 3,
   parameter int FBANK_W = 5,
   parameter int DATA_W  = 15,
   parameter int OUT_W   = 16
);
   // Handshake: a transfer happens on a rising edge where valid & ready are both high.
   // The producer holds valid and payload until that edge; ready may depend on valid.
   logic                wr_en;
   logic [11:0]         wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                sb_wr_en;
   logic                sb_data;
   logic                req_valid;
   logic                req_ready;
   logic [11:0]         req_addr;
   logic                resp_valid;
   logic                resp_ready;
   logic [OUT_W-1:0]    resp_addr;
   logic [1:0]          resp_region;
   logic                resp_super;
   logic [EBANK_W-1:0]  eb;
   logic [FBANK_W-1:0]  fb;
   logic                sb;

   modport master (
      output wr_en, wr_addr, wr_data, sb_wr_en, sb_data,
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_addr, resp_region, resp_super,
      input  eb, fb, sb
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, sb_wr_en, sb_data,
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_addr, resp_region, resp_super,
      output eb, fb, sb
   );
endinterface

// File: rtl/agc_bank_mmu.sv
// Registered bank-aware address translator: holds EB/FB/BB bank state and the superbank
// bit, translates 12-bit CPU addresses to OUT_W-bit physical addresses with 1-cycle latency.
module agc_bank_mmu #(
   parameter int          EBANK_W = 3,
   parameter int          FBANK_W = 5,
   parameter int          DATA_W  = 15,
   parameter int          OUT_W   = 16,
   parameter logic [11:0] EB_ADDR = 12'o3,
   parameter logic [11:0] FB_ADDR = 12'o4,
   parameter logic [11:0] BB_ADDR = 12'o6
) (
   input  logic          clk,
   input  logic          reset,
   agc_bank_mmu_if.slave bus
);

   logic [EBANK_W-1:0] r_eb;
   logic [FBANK_W-1:0] r_fb;
   logic               r_sb;
   logic               r_resp_valid;
   logic [OUT_W-1:0]   r_resp_addr;
   logic [1:0]         r_resp_region;
   logic               r_resp_super;

   logic               w_accept;
   logic               w_req_ready;
   logic [OUT_W-1:0]   w_addr;
   logic [1:0]         w_region;
   logic               w_super;
   logic [11:0]        w_a;

   assign w_a         = bus.req_addr;
   assign w_req_ready = !r_resp_valid || bus.resp_ready;
   assign w_accept    = bus.req_valid && w_req_ready;

   // Translation always uses the bank registers as they stand before any same-cycle write.
   always_comb begin
      w_addr   = '0;
      w_region = 2'd0;
      w_super  = 1'b0;
      if (w_a[11]) begin
         w_addr   = OUT_W'(w_a);
         w_region = 2'd3;
      end else if (w_a[10]) begin
         w_region = 2'd2;
         if (r_fb[FBANK_W-1 -: 2] == 2'b11 && r_sb) begin
            w_addr  = OUT_W'({1'b1, 2'b00, r_fb[FBANK_W-3:0], w_a[9:0]});
            w_super = 1'b1;
         end else begin
            w_addr  = OUT_W'({1'b0, r_fb, w_a[9:0]});
         end
      end else if (w_a[9:8] == 2'b11) begin
         w_addr   = OUT_W'({r_eb, w_a[7:0]});
         w_region = 2'd1;
      end else begin
         w_addr   = OUT_W'(w_a[9:0]);
         w_region = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_eb <= '0;
         r_fb <= '0;
         r_sb <= 1'b0;
      end else begin
         if (bus.wr_en) begin
            if (bus.wr_addr == EB_ADDR) begin
               r_eb <= bus.wr_data[8 +: EBANK_W];
            end else if (bus.wr_addr == FB_ADDR) begin
               r_fb <= bus.wr_data[DATA_W-1 -: FBANK_W];
            end else if (bus.wr_addr == BB_ADDR) begin
               r_fb <= bus.wr_data[DATA_W-1 -: FBANK_W];
               r_eb <= bus.wr_data[0 +: EBANK_W];
            end
         end
         if (bus.sb_wr_en) begin
            r_sb <= bus.sb_data;
         end
      end
   end

   // Output stage: loads on accept, empties when drained with nothing new, else holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_resp_valid  <= 1'b0;
         r_resp_addr   <= '0;
         r_resp_region <= 2'd0;
         r_resp_super  <= 1'b0;
      end else if (w_accept) begin
         r_resp_valid  <= 1'b1;
         r_resp_addr   <= w_addr;
         r_resp_region <= w_region;
         r_resp_super  <= w_super;
      end else if (bus.resp_ready) begin
         r_resp_valid  <= 1'b0;
      end
   end

   assign bus.req_ready   = w_req_ready;
   assign bus.resp_valid  = r_resp_valid;
   assign bus.resp_addr   = r_resp_addr;
   assign bus.resp_region = r_resp_region;
   assign bus.resp_super  = r_resp_super;
   assign bus.eb          = r_eb;
   assign bus.fb          = r_fb;
   assign bus.sb          = r_sb;

endmodule
